// File: rtl/pool_frame_ctrl.sv
// pool_frame_ctrl: frame sequencer feeding K lock-step pooling channels, counting outputs, detecting errors
module pool_frame_ctrl #(
  parameter int K_CHANNELS    = 6,
  parameter int MAX_LINE_W    = 32,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_async_n_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [15:0]           cfg_img_w_i,
  input  logic [15:0]           cfg_img_h_i,
  input  logic                  up_valid_i,
  output logic                  up_ready_o,
  output logic [K_CHANNELS-1:0] pool_valid_o,
  input  logic [K_CHANNELS-1:0] pool_ready_i,
  input  logic [K_CHANNELS-1:0] pool_out_valid_i,
  input  logic [K_CHANNELS-1:0] pool_out_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [15:0]           in_row_o,
  output logic [15:0]           in_col_o,
  output logic [15:0]           out_cnt_o
);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t        state;
  logic [15:0]   img_w, img_h, out_next;
  logic [TW-1:0] timer;
  logic [31:0]   target;
  logic          all_rdy, in_beat, out_beat, skew, cfg_ok, last_col, last_px, unused_ok;
  // Channels run in lock-step: a pixel is only offered when every channel can take it.
  assign all_rdy      = &pool_ready_i;
  assign up_ready_o   = (state == FEED) && all_rdy;
  assign in_beat      = up_ready_o && up_valid_i;
  assign pool_valid_o = {K_CHANNELS{in_beat}};
  // Channel 0 stands in for all channels when counting outputs; the others are only skew-checked.
  assign out_beat  = ((state == FEED) || (state == DRAIN)) && pool_out_valid_i[0] && pool_out_ready_i[0];
  assign skew      = (|pool_out_valid_i) && !(&pool_out_valid_i);
  assign unused_ok = ^pool_out_ready_i;
  assign cfg_ok    = !cfg_img_w_i[0] && !cfg_img_h_i[0] && (cfg_img_w_i >= 16'd2) &&
                     (cfg_img_h_i >= 16'd2) && (cfg_img_w_i <= 16'(MAX_LINE_W));
  assign last_col  = in_col_o == img_w - 16'd1;
  assign last_px   = last_col && (in_row_o == img_h - 16'd1);
  assign out_next  = out_cnt_o + {15'd0, out_beat};
  assign target    = 32'(img_w[15:1]) * 32'(img_h[15:1]);
  // Frame FSM with registered status outputs; abort outranks every other transition.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state      <= IDLE;
      img_w      <= '0;
      img_h      <= '0;
      in_row_o   <= '0;
      in_col_o   <= '0;
      out_cnt_o  <= '0;
      timer      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (state == IDLE) begin
        if (start_i && cfg_ok) begin
          state      <= FEED;
          busy_o     <= 1'b1;
          img_w      <= cfg_img_w_i;
          img_h      <= cfg_img_h_i;
          in_row_o   <= '0;
          in_col_o   <= '0;
          out_cnt_o  <= '0;
          timer      <= '0;
          err_code_o <= 2'd0;
        end else if (start_i) begin
          err_o      <= 1'b1;
          err_code_o <= 2'd1;
        end
      end else if (abort_i) begin
        state     <= IDLE;
        busy_o    <= 1'b0;
        in_row_o  <= '0;
        in_col_o  <= '0;
        out_cnt_o <= '0;
        timer     <= '0;
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (skew) begin
        state      <= IDLE;
        busy_o     <= 1'b0;
        err_o      <= 1'b1;
        err_code_o <= 2'd3;
      end else begin
        out_cnt_o <= out_next;
        if (state == FEED) begin
          if (in_beat) begin
            in_col_o <= last_col ? 16'd0 : in_col_o + 16'd1;
            if (last_col) in_row_o <= in_row_o + 16'd1;
            if (last_px) state <= DRAIN;
          end
        end else if ({16'd0, out_next} >= target) begin
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end else if (!out_beat && (timer == TW'(DRAIN_TIMEOUT - 1))) begin
          state      <= IDLE;
          busy_o     <= 1'b0;
          err_o      <= 1'b1;
          err_code_o <= 2'd2;
        end else begin
          timer <= out_beat ? '0 : timer + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pool_frame_ctrl.sv
// tb_pool_frame_ctrl: random frames against a pixel/output-count model with an event scoreboard
module tb_pool_frame_ctrl;
  localparam int K = 6;
  localparam int MAXW = 32;
  localparam int TO = 256;

  typedef struct {
    int kind;
    int code;
    int w;
    int h;
    int cyc;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, up_valid = 1'b0;
  logic [15:0] cw = '0, ch = '0;
  logic [K-1:0] pool_ready = '1, pov = '0, por = '0;
  logic up_ready, busy, done, err;
  logic [K-1:0] pool_valid;
  logic [1:0] ecode;
  logic [15:0] row, col, ocnt;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;
  bit fr_on = 1'b0;
  int fr_w = 1, fr_h = 1, in_seen = 0, out_seen = 0, last_in = 0, last_out = 0;

  pool_frame_ctrl #(.K_CHANNELS(K), .MAX_LINE_W(MAXW), .DRAIN_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_async_n_i(rst_n), .start_i(start), .abort_i(abort),
    .cfg_img_w_i(cw), .cfg_img_h_i(ch), .up_valid_i(up_valid), .up_ready_o(up_ready),
    .pool_valid_o(pool_valid), .pool_ready_i(pool_ready),
    .pool_out_valid_i(pov), .pool_out_ready_i(por),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(ecode),
    .in_row_o(row), .in_col_o(col), .out_cnt_o(ocnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(int w, int h, bit exp_done);
    exp_t e;
    bit ok;
    ok = (w % 2 == 0) && (h % 2 == 0) && (w >= 2) && (h >= 2) && (w <= MAXW);
    start = 1'b1;
    cw = 16'(w);
    ch = 16'(h);
    if (!ok) begin
      e.kind = 1; e.code = 1; e.w = w; e.h = h; e.cyc = cyc + 2;
      q.push_back(e);
    end
    tick();
    start = 1'b0;
    if (ok) begin
      fr_on = 1'b1; fr_w = w; fr_h = h;
      in_seen = 0; out_seen = 0; last_in = 0; last_out = 0;
      if (exp_done) begin
        e.kind = 0; e.code = 0; e.w = w; e.h = h; e.cyc = 0;
        q.push_back(e);
      end
    end
  endtask

  task automatic feed(int n, bit rnd, int hold_at);
    int got = 0, guard = 0, hold = 0;
    while (got < n && guard < 5000) begin
      up_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      pool_ready = '1;
      if (hold_at == got && hold < 5) begin
        pool_ready = 6'b110111;
        up_valid = 1'b1;
        hold++;
      end else if (rnd && $urandom_range(0, 7) == 0) begin
        pool_ready = 6'h3f & ~(6'd1 << $urandom_range(0, 5));
      end
      #1;
      if (up_valid && up_ready) got++;
      tick();
      guard++;
    end
    up_valid = 1'b0;
    pool_ready = '1;
    chk("feed_beats", got, n);
  endtask

  task automatic emit(int n);
    int got = 0;
    while (got < n) begin
      pov = '0;
      por = 6'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      pov = '1;
      por = ($urandom_range(0, 3) == 0) ? 6'h3e : 6'h3f;
      if (por[0]) got++;
      tick();
    end
    pov = '0;
    por = '0;
  endtask

  task automatic wait_end(int lim);
    int i = 0;
    while (fr_on && i < lim) begin
      tick();
      i++;
    end
    chk("frame_end_in_time", fr_on, 0);
    fr_on = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_col"}, col, 0);
    chk({tag, "_out_cnt"}, ocnt, 0);
    chk({tag, "_up_ready"}, up_ready, 0);
    chk({tag, "_pool_valid"}, pool_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    fork
      begin : mon
        exp_t e;
        int x;
        bit feeding;
        forever begin
          @(negedge clk);
          cyc++;
          if (!rst_n) begin
            fr_on = 1'b0;
          end else begin
            if (done || err) begin
              if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: done=%0b err=%0b code=%0d, required no event (cycle %0d)", done, err, ecode, cyc);
              end else begin
                e = q.pop_front();
                chk("event_done", done, e.kind == 0);
                chk("event_err", err, e.kind == 1);
                chk("event_err_code", ecode, e.code);
                if (e.kind == 0) begin
                  x = (last_in + 2 > last_out + 1) ? last_in + 2 : last_out + 1;
                  chk("done_out_cnt", ocnt, (e.w / 2) * (e.h / 2));
                  chk("done_in_beats", in_seen, e.w * e.h);
                end else if (e.code == 2) begin
                  x = ((last_in > last_out) ? last_in : last_out) + 1 + TO;
                end else begin
                  x = e.cyc;
                end
                chk("event_cycle", cyc, x);
                fr_on = 1'b0;
              end
            end
            feeding = fr_on && (in_seen < fr_w * fr_h);
            chk("busy", busy, fr_on);
            chk("up_ready", up_ready, feeding && (&pool_ready));
            chk("pool_valid", pool_valid, (feeding && (&pool_ready) && up_valid) ? 6'h3f : 6'h00);
            if (fr_on) begin
              chk("in_row", row, in_seen / fr_w);
              chk("in_col", col, in_seen % fr_w);
              chk("out_cnt", ocnt, out_seen);
              if (up_valid && up_ready) begin
                in_seen++;
                last_in = cyc;
              end
              if (pov[0] && por[0]) begin
                out_seen++;
                last_out = cyc;
              end
            end
          end
        end
      end
      begin : drv
        exp_t e;
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        chk("reset_err_code", ecode, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        start_frame(23, 24, 0);
        repeat (3) tick();
        start_frame(34, 24, 0);
        repeat (3) tick();
        start_frame(4, 3, 0);
        repeat (3) tick();
        chk("err_code_hold", ecode, 1);

        start_frame(24, 24, 1);
        start = 1'b1;
        cw = 16'd3;
        ch = 16'd3;
        tick();
        start = 1'b0;
        fork
          feed(576, 0, 100);
          emit(144);
        join
        wait_end(600);
        tick();
        chk("hold_out_cnt", ocnt, 144);
        chk("hold_row", row, 24);

        for (int i = 0; i < 4; i++) begin
          int w, h;
          w = 2 * $urandom_range(1, MAXW / 2);
          h = 2 * $urandom_range(1, 8);
          start_frame(w, h, 1);
          fork
            feed(w * h, 1, $urandom_range(0, 3));
            emit((w / 2) * (h / 2));
          join
          wait_end(600);
          repeat ($urandom_range(0, 2)) tick();
        end

        start_frame(4, 4, 0);
        e.kind = 1; e.code = 2; e.w = 4; e.h = 4; e.cyc = 0;
        q.push_back(e);
        fork
          feed(16, 1, -1);
          emit(2);
        join
        wait_end(400);

        start_frame(8, 8, 0);
        feed(10, 1, -1);
        pov = 6'b000001;
        por = '1;
        e.kind = 1; e.code = 3; e.w = 8; e.h = 8; e.cyc = cyc + 2;
        q.push_back(e);
        tick();
        pov = '0;
        por = '0;
        wait_end(10);

        start_frame(24, 24, 0);
        fork
          feed(120, 0, -1);
          emit(10);
        join
        abort = 1'b1;
        up_valid = 1'b1;
        tick();
        abort = 1'b0;
        up_valid = 1'b0;
        fr_on = 1'b0;
        chk_zero("abort");
        repeat (3) tick();
        start_frame(24, 24, 1);
        fork
          feed(576, 1, -1);
          emit(144);
        join
        wait_end(600);

        start_frame(8, 8, 0);
        fork
          feed(20, 1, -1);
          emit(3);
        join
        up_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        chk("mid_reset_err_code", ecode, 0);
        fr_on = 1'b0;
        tick();
        rst_n = 1'b1;
        up_valid = 1'b0;
        tick();
        start_frame(6, 4, 1);
        fork
          feed(24, 1, -1);
          emit(6);
        join
        wait_end(600);

        repeat (5) tick();
        chk("events_outstanding", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_any
  end
endmodule

// File: doc/pool_frame_ctrl.md
POOL_FRAME_CTRL -- requirements
Module: pool_frame_ctrl

Interface
REQ-001 SHALL have parameter K_CHANNELS, default 6: number of lock-step pooling channels.
REQ-002 SHALL have parameter MAX_LINE_W, default 32: largest legal input image width.
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 256: idle-cycle limit while draining.
REQ-004 SHALL have ports, in this order:
- clk_i  input  1  single clock; all logic rising-edge.
- rst_async_n_i  input  1  reset, asynchronous assert, active-low.
- start_i  input  1  single-cycle frame start request.
- abort_i  input  1  synchronous abort of the current frame.
- cfg_img_w_i  input  16  input image width, sampled on accepted start.
- cfg_img_h_i  input  16  input image height, sampled on accepted start.
- up_valid_i  input  1  upstream conv pixel valid.
- up_ready_o  output  1  upstream ready.
- pool_valid_o  output  K_CHANNELS  broadcast valid to pooling_top.
- pool_ready_i  input  K_CHANNELS  pooling_top per-channel ready.
- pool_out_valid_i  input  K_CHANNELS  pooling_top output valid (monitored).
- pool_out_ready_i  input  K_CHANNELS  downstream ready for pooling output (monitored).
- busy_o  output  1  high in FEED or DRAIN.
- done_o  output  1  one-cycle frame-complete pulse.
- err_o  output  1  one-cycle error pulse.
- err_code_o  output  2  0 none, 1 bad config, 2 drain timeout, 3 channel skew; held until next accepted start.
- in_row_o, in_col_o  output  16 each  position of the next input pixel.
- out_cnt_o  output  16  pooled outputs observed this frame.

Function
REQ-005 SHALL implement states IDLE, FEED, DRAIN, DONE.
REQ-006 IDLE: start_i=1 with legal config SHALL latch W/H, clear counters and err_code_o, and enter FEED next cycle.
REQ-007 Legal config: W and H even, both >=2, W<=MAX_LINE_W; otherwise SHALL pulse err_o, set err_code_o=1, remain IDLE.
REQ-008 start_i outside IDLE SHALL be ignored.
REQ-009 all_rdy = AND of pool_ready_i; in FEED, up_ready_o=all_rdy and pool_valid_o={K{up_valid_i & all_rdy}}; outside FEED both SHALL be 0.
REQ-010 Input beat = FEED & up_valid_i & all_rdy; on each beat in_col increments, wraps W-1->0 with in_row increment.
REQ-011 Beat at (H-1, W-1) SHALL enter DRAIN next cycle; no further beats accepted.
REQ-012 Output beat = pool_out_valid_i[0] & pool_out_ready_i[0] in FEED or DRAIN; each increments out_cnt.
REQ-013 In FEED/DRAIN, any cycle where pool_out_valid_i is neither all-0 nor all-1 SHALL pulse err_o, set err_code_o=3, go IDLE.
REQ-014 DRAIN: when out_cnt reaches (W/2)*(H/2), SHALL enter DONE; if that count is reached in FEED, transition still waits for REQ-011.
REQ-015 DRAIN: a timer counts cycles without output beat, clears on each beat; reaching DRAIN_TIMEOUT SHALL pulse err_o, err_code_o=2, go IDLE.
REQ-016 DONE: done_o=1 for exactly that one cycle, then IDLE; counters hold final values until next start.
REQ-017 abort_i in FEED/DRAIN/DONE SHALL go IDLE next cycle, zero counters, no done_o, no err_o; abort_i has priority over all other transitions.
REQ-018 busy_o SHALL be registered state decode (FEED or DRAIN).

Reset
REQ-019 Asserting rst_async_n_i SHALL immediately force IDLE, all counters/timer 0, err_code_o=0, and all outputs 0.
REQ-020 Reset mid-frame SHALL discard frame; first post-reset start behaves as from power-up.

Verification
REQ-021 W=H=24, up_valid_i=1, all ready: 576 input beats, up_ready_o low after beat 576, done_o one cycle after 144th output beat, out_cnt_o=144.
REQ-022 start with W=23, H=24 -> err_o one pulse, err_code_o=1, busy_o stays 0; start with W=34 -> same.
REQ-023 During FEED, pool_ready_i[3]=0 for 5 cycles -> up_ready_o=0, pool_valid_o=0, in_row_o/in_col_o frozen for those 5 cycles; resumes without loss.
REQ-024 W=H=4, withhold output beats after last input -> err_o at cycle 256 of DRAIN, err_code_o=2, state IDLE.
REQ-025 abort_i at in_row_o=5 -> next cycle busy_o=0, counters 0, no done_o/err_o; new 24x24 start completes normally.
REQ-026 pool_out_valid_i=6'b000001 during FEED -> err_o, err_code_o=3, IDLE.
